// File: rtl/auc_host_seq.sv
// Host command sequencer in front of the arithmetic-unit controller: one command in, one AUC
// operation with timeout, one response out. Define AUC_HOST_SEQ_CYCCNT_EN to add the rsp_cyc latency output.
module auc_host_seq #(
  parameter int unsigned     WIDTH = 256,
  parameter int unsigned     TWID  = 20,
  parameter logic [TWID-1:0] TOUT  = 20'hFFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_vld,
  output logic             cmd_rdy,
  input  logic [3:0]       cmd_mode,
  input  logic [WIDTH-1:0] cmd_dat,
  output logic             rsp_vld,
  input  logic             rsp_rdy,
  output logic [WIDTH-1:0] rsp_dat,
  output logic [1:0]       rsp_code,
`ifdef AUC_HOST_SEQ_CYCCNT_EN
  output logic [TWID-1:0]  rsp_cyc,
`endif
  output logic [WIDTH-1:0] auc_dat,
  output logic             auc_start,
  output logic [3:0]       auc_mode,
  input  logic [WIDTH-1:0] auc_rslt,
  input  logic [1:0]       auc_status
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_HOLD  = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  localparam logic [1:0] ST_DONE  = 2'b10;
  localparam logic [1:0] ST_ERROR = 2'b11;
  localparam logic [1:0] RC_OK    = 2'b00;
  localparam logic [1:0] RC_ERR   = 2'b01;
  localparam logic [1:0] RC_TOUT  = 2'b10;
  localparam logic [TWID-1:0] TLAST = TOUT - TWID'(1);

  state_e           state_q, state_d;
  logic [TWID-1:0]  timer_q, timer_d;
  logic             cmd_rdy_q, cmd_rdy_d;
  logic             auc_start_q, auc_start_d;
  logic [3:0]       auc_mode_q, auc_mode_d;
  logic [WIDTH-1:0] auc_dat_q, auc_dat_d;
  logic             rsp_vld_q, rsp_vld_d;
  logic [WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic [1:0]       rsp_code_q, rsp_code_d;
`ifdef AUC_HOST_SEQ_CYCCNT_EN
  logic [TWID-1:0]  rsp_cyc_q, rsp_cyc_d;
`endif

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    auc_mode_d = auc_mode_q;
    auc_dat_d  = auc_dat_q;
    rsp_dat_d  = rsp_dat_q;
    rsp_code_d = rsp_code_q;
`ifdef AUC_HOST_SEQ_CYCCNT_EN
    rsp_cyc_d  = rsp_cyc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_vld && cmd_rdy_q) begin
          auc_mode_d = cmd_mode;
          auc_dat_d  = cmd_dat;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_HOLD;
      S_HOLD: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TWID'(1);
`ifdef AUC_HOST_SEQ_CYCCNT_EN
        rsp_cyc_d = timer_q + TWID'(1);
`endif
        // A status pulse wins over a coincident expiry.
        if (auc_status == ST_DONE) begin
          rsp_dat_d  = auc_rslt;
          rsp_code_d = RC_OK;
          state_d    = S_RESP;
        end else if (auc_status == ST_ERROR) begin
          rsp_dat_d  = auc_rslt;
          rsp_code_d = RC_ERR;
          state_d    = S_RESP;
        end else if (timer_q == TLAST) begin
          rsp_dat_d  = '0;
          rsp_code_d = RC_TOUT;
          state_d    = S_RESP;
        end else begin
`ifdef AUC_HOST_SEQ_CYCCNT_EN
          rsp_cyc_d = rsp_cyc_q;
`endif
        end
      end
      S_RESP: begin
        if (rsp_vld_q && rsp_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered from the next state so they line up with the state they describe.
    cmd_rdy_d   = (state_d == S_IDLE);
    auc_start_d = (state_d == S_ISSUE);
    rsp_vld_d   = (state_d == S_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      cmd_rdy_q   <= 1'b0;
      auc_start_q <= 1'b0;
      auc_mode_q  <= '0;
      auc_dat_q   <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_code_q  <= '0;
`ifdef AUC_HOST_SEQ_CYCCNT_EN
      rsp_cyc_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cmd_rdy_q   <= cmd_rdy_d;
      auc_start_q <= auc_start_d;
      auc_mode_q  <= auc_mode_d;
      auc_dat_q   <= auc_dat_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_code_q  <= rsp_code_d;
`ifdef AUC_HOST_SEQ_CYCCNT_EN
      rsp_cyc_q   <= rsp_cyc_d;
`endif
    end
  end

  assign cmd_rdy   = cmd_rdy_q;
  assign auc_start = auc_start_q;
  assign auc_mode  = auc_mode_q;
  assign auc_dat   = auc_dat_q;
  assign rsp_vld   = rsp_vld_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_code  = rsp_code_q;
`ifdef AUC_HOST_SEQ_CYCCNT_EN
  assign rsp_cyc   = rsp_cyc_q;
`endif

endmodule

// File: tb/tb_auc_host_seq.sv
// Directed bench for auc_host_seq: instance a uses the default timeout, instance b uses a 16-cycle timeout.
module tb_auc_host_seq;
  localparam int W = 256;
  localparam logic [1:0] ST_IDLE = 2'b00, ST_CAL = 2'b01, ST_DONE = 2'b10, ST_ERR = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_vld = 1'b0, rsp_rdy = 1'b0;
  logic [3:0] cmd_mode = '0;
  logic [W-1:0] cmd_dat = '0, auc_rslt = '0;
  logic [1:0] auc_status = '0;
  logic sel = 1'b0;

  logic a_cmd_rdy, a_rsp_vld, a_auc_start, b_cmd_rdy, b_rsp_vld, b_auc_start;
  logic [W-1:0] a_rsp_dat, a_auc_dat, b_rsp_dat, b_auc_dat;
  logic [1:0] a_rsp_code, b_rsp_code;
  logic [3:0] a_auc_mode, b_auc_mode;
  logic [19:0] a_rsp_cyc, b_rsp_cyc;

  logic m_cmd_rdy, m_rsp_vld, m_auc_start;
  logic [W-1:0] m_rsp_dat, m_auc_dat;
  logic [1:0] m_rsp_code;
  logic [3:0] m_auc_mode;
  logic [19:0] m_rsp_cyc;

  always #5 clk = ~clk;

  auc_host_seq dut_a (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(a_cmd_rdy), .cmd_mode(cmd_mode),
    .cmd_dat(cmd_dat), .rsp_vld(a_rsp_vld), .rsp_rdy(rsp_rdy), .rsp_dat(a_rsp_dat),
    .rsp_code(a_rsp_code),
`ifdef AUC_HOST_SEQ_CYCCNT_EN
    .rsp_cyc(a_rsp_cyc),
`endif
    .auc_dat(a_auc_dat), .auc_start(a_auc_start), .auc_mode(a_auc_mode),
    .auc_rslt(auc_rslt), .auc_status(auc_status));

  auc_host_seq #(.TOUT(20'd16)) dut_b (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(b_cmd_rdy), .cmd_mode(cmd_mode),
    .cmd_dat(cmd_dat), .rsp_vld(b_rsp_vld), .rsp_rdy(rsp_rdy), .rsp_dat(b_rsp_dat),
    .rsp_code(b_rsp_code),
`ifdef AUC_HOST_SEQ_CYCCNT_EN
    .rsp_cyc(b_rsp_cyc),
`endif
    .auc_dat(b_auc_dat), .auc_start(b_auc_start), .auc_mode(b_auc_mode),
    .auc_rslt(auc_rslt), .auc_status(auc_status));

`ifndef AUC_HOST_SEQ_CYCCNT_EN
  assign a_rsp_cyc = '0;
  assign b_rsp_cyc = '0;
`endif

  assign m_cmd_rdy   = sel ? b_cmd_rdy   : a_cmd_rdy;
  assign m_rsp_vld   = sel ? b_rsp_vld   : a_rsp_vld;
  assign m_auc_start = sel ? b_auc_start : a_auc_start;
  assign m_rsp_dat   = sel ? b_rsp_dat   : a_rsp_dat;
  assign m_auc_dat   = sel ? b_auc_dat   : a_auc_dat;
  assign m_rsp_code  = sel ? b_rsp_code  : a_rsp_code;
  assign m_auc_mode  = sel ? b_auc_mode  : a_auc_mode;
  assign m_rsp_cyc   = sel ? b_rsp_cyc   : a_rsp_cyc;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_vld = 1'b0; rsp_rdy = 1'b0; auc_status = ST_IDLE; auc_rslt = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // n: WAIT cycle (1-based) in which stat is driven; hold: extra RESP cycles with rsp_rdy low
  typedef struct {
    logic         sel;
    logic [3:0]   mode;
    logic [W-1:0] dat;
    logic [1:0]   stat;
    int           n;
    int           hold;
    logic [W-1:0] rslt;
    logic [1:0]   exp_code;
    logic [W-1:0] exp_dat;
    int           exp_cyc;
  } vec_t;

  vec_t vecs[7];

  task automatic run(input vec_t v);
    sel = v.sel;
    chk("cmd_rdy_idle", W'(m_cmd_rdy), W'(1));
    cmd_vld = 1'b1; cmd_mode = v.mode; cmd_dat = v.dat;
    tick();
    cmd_vld = 1'b0; cmd_dat = '1;
    chk("start_issue", W'(m_auc_start), W'(1));
    chk("auc_dat_issue", m_auc_dat, v.dat);
    chk("auc_mode_issue", W'(m_auc_mode), W'(v.mode));
    chk("cmd_rdy_busy", W'(m_cmd_rdy), W'(0));
    tick();
    chk("start_hold", W'(m_auc_start), W'(0));
    chk("auc_dat_hold", m_auc_dat, v.dat);
    tick();
    for (int k = 1; k < v.n; k++) tick();
    chk("rsp_vld_pre", W'(m_rsp_vld), W'(0));
    auc_status = v.stat; auc_rslt = v.rslt;
    tick();
    auc_status = ST_IDLE;
    chk("rsp_vld", W'(m_rsp_vld), W'(1));
    chk("rsp_code", W'(m_rsp_code), W'(v.exp_code));
    chk("rsp_dat", m_rsp_dat, v.exp_dat);
`ifdef AUC_HOST_SEQ_CYCCNT_EN
    chk("rsp_cyc", W'(m_rsp_cyc), W'(v.exp_cyc));
`endif
    for (int h = 0; h < v.hold; h++) begin
      if (h == 1) begin auc_status = ST_DONE; auc_rslt = 256'hBAD; end
      tick();
      auc_status = ST_IDLE;
      chk("rsp_vld_held", W'(m_rsp_vld), W'(1));
      chk("rsp_dat_held", m_rsp_dat, v.exp_dat);
      chk("rsp_code_held", W'(m_rsp_code), W'(v.exp_code));
      chk("cmd_rdy_held", W'(m_cmd_rdy), W'(0));
    end
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
    chk("rsp_vld_done", W'(m_rsp_vld), W'(0));
    chk("cmd_rdy_after", W'(m_cmd_rdy), W'(1));
    chk("auc_dat_kept", m_auc_dat, v.dat);
    chk("auc_mode_kept", W'(m_auc_mode), W'(v.mode));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 4'h5, 256'h1234, ST_DONE, 40, 0, 256'hBEEF, 2'b00, 256'hBEEF, 40};
    vecs[1] = '{1'b0, 4'h1, 256'h77,   ST_ERR,  7,  0, 256'hDEAD, 2'b01, 256'hDEAD, 7};
    vecs[2] = '{1'b1, 4'hA, 256'h55,   ST_IDLE, 16, 0, 256'h99,   2'b10, 256'h0,    16};
    vecs[3] = '{1'b1, 4'h3, 256'h66,   ST_DONE, 16, 0, 256'hCAFE, 2'b00, 256'hCAFE, 16};
    vecs[4] = '{1'b0, 4'hC, {W{1'b1}}, ST_DONE, 1,  10, 256'h1,   2'b00, 256'h1,    1};
    vecs[5] = '{1'b1, 4'h4, 256'h88,   ST_CAL,  16, 0, 256'h42,   2'b10, 256'h0,    16};
    vecs[6] = '{1'b1, 4'hB, 256'h99,   ST_ERR,  15, 0, 256'hF00D, 2'b01, 256'hF00D, 15};

    // reset state
    tick();
    chk("rst_cmd_rdy", W'(a_cmd_rdy), W'(0));
    chk("rst_rsp_vld", W'(a_rsp_vld), W'(0));
    chk("rst_auc_dat", a_auc_dat, W'(0));
    rst = 1'b0;
    chk("rel_cmd_rdy_pre", W'(a_cmd_rdy), W'(0));
    tick();
    chk("rel_cmd_rdy", W'(a_cmd_rdy), W'(1));
    chk("rel_rsp_vld", W'(a_rsp_vld), W'(0));
    chk("rel_auc_start", W'(a_auc_start), W'(0));
    chk("rel_auc_mode", W'(a_auc_mode), W'(0));

    for (int i = 0; i < 7; i++) begin
      do_reset();
      run(vecs[i]);
    end

    // late DONE after a timeout produces nothing
    do_reset();
    run(vecs[2]);
    auc_status = ST_DONE; auc_rslt = 256'h5;
    tick();
    auc_status = ST_IDLE;
    tick();
    chk("late_done_vld", W'(b_rsp_vld), W'(0));

    // async reset mid-WAIT
    do_reset();
    sel = 1'b0;
    cmd_vld = 1'b1; cmd_mode = 4'h7; cmd_dat = 256'hABC;
    tick();
    cmd_vld = 1'b0;
    tick(); tick();
    for (int k = 0; k < 4; k++) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_start", W'(a_auc_start), W'(0));
    chk("arst_mode", W'(a_auc_mode), W'(0));
    chk("arst_dat", a_auc_dat, W'(0));
    chk("arst_rsp_vld", W'(a_rsp_vld), W'(0));
    chk("arst_cmd_rdy", W'(a_cmd_rdy), W'(0));
    tick();
    rst = 1'b0;
    tick();
    auc_status = ST_DONE; auc_rslt = 256'h5;
    tick();
    auc_status = ST_IDLE;
    tick();
    chk("arst_late_vld", W'(a_rsp_vld), W'(0));
    chk("arst_cmd_rdy_idle", W'(a_cmd_rdy), W'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
